// File: rtl/qracc_pkg.sv
// qracc_pkg: scheduler state encoding, default accumulator width and ADC midpoint helper.
package qracc_pkg;
  typedef enum logic [2:0] {IDLE, SRAM_REQ, SRAM_RD, MAC_DRIVE, MAC_SAMPLE, MAC_WAIT, RESULT} sched_state_t;
  localparam int ACC_BITS = 16;
  function automatic int adc_mid(input int bits);
    return 1 << (bits - 1);
  endfunction
endpackage

// File: rtl/qracc_shift_acc.sv
// qracc_shift_acc: per-column signed shift-accumulator of midpoint-centred ADC codes.
module qracc_shift_acc
  import qracc_pkg::*;
#(
  parameter int ADC_BITS = 4,
  parameter int ACC_W = ACC_BITS
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                clr,
  input  logic                en,
  input  logic                sign,
  input  logic [ADC_BITS-1:0] code,
  output logic [ACC_W-1:0]    acc
);
  logic signed [ADC_BITS:0] d, sd;
  always_comb begin
    d = $signed({1'b0, code}) - $signed((ADC_BITS+1)'(adc_mid(ADC_BITS)));
    sd = sign ? -d : d;
  end
  // MSB-first planes: shift previous partial sum, then add this plane's weighted sample
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= (acc << 1) + {{(ACC_W-ADC_BITS-1){sd[ADC_BITS]}}, sd};
endmodule

// File: rtl/qracc_column_scheduler.sv
// qracc_column_scheduler: arbitrates the column between host SRAM access and
// bit-serial ternary MAC planes, accumulating a signed result per column.
module qracc_column_scheduler
  import qracc_pkg::*;
#(
  parameter int numRows = 128,
  parameter int numCols = 1,
  parameter int numAdcBits = 4,
  parameter int numCfgBits = 8,
  parameter int accBits = ACC_BITS
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [numCfgBits-1:0]        cfg_settle_i,
  input  logic                         h_rq_valid_i,
  output logic                         h_rq_ready_o,
  input  logic                         h_rq_wr_i,
  input  logic [$clog2(numRows)-1:0]   h_addr_i,
  input  logic [numCols-1:0]           h_wr_data_i,
  output logic                         h_rd_valid_o,
  output logic [numCols-1:0]           h_rd_data_o,
  input  logic                         pl_valid_i,
  output logic                         pl_ready_o,
  input  logic [numRows-1:0]           pl_p_i,
  input  logic [numRows-1:0]           pl_n_i,
  input  logic                         pl_sign_i,
  input  logic                         pl_last_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [numCols*accBits-1:0]   res_data_o,
  output logic                         mac_en_o,
  output logic [numRows-1:0]           data_p_o,
  output logic [numRows-1:0]           data_n_o,
  output logic                         rq_valid_o,
  output logic                         rq_wr_o,
  output logic [$clog2(numRows)-1:0]   addr_o,
  output logic [numCols-1:0]           wr_data_o,
  input  logic [numCols*numAdcBits-1:0] adc_out_i,
  input  logic                         rq_ready_i,
  input  logic                         rd_valid_i,
  input  logic [numCols-1:0]           rd_data_i
);
  localparam int AW = $clog2(numRows);
  sched_state_t state;
  logic rr, wr, sign, last, h_rd_valid, mac_req, grant_host, grant_mac, accept, mac;
  logic [AW-1:0] addr;
  logic [numCols-1:0] wdata, rdata;
  logic [numRows-1:0] p, n;
  logic [numCfgBits-1:0] cnt;
  // rr=0 favours the host; whichever side wins becomes the lower priority
  always_comb begin
    mac_req = pl_valid_i && !res_valid_o;
    grant_host = state == IDLE && h_rq_valid_i && (!mac_req || !rr);
    grant_mac = state == IDLE && mac_req && (!h_rq_valid_i || rr);
    accept = grant_mac || (pl_valid_i && (state == MAC_WAIT || (state == MAC_SAMPLE && !last)));
    mac = state inside {MAC_DRIVE, MAC_SAMPLE, MAC_WAIT};
  end
  assign h_rq_ready_o = grant_host;
  assign pl_ready_o = accept;
  assign mac_en_o = mac;
  assign data_p_o = mac ? p : '0;
  assign data_n_o = mac ? n : '0;
  assign rq_valid_o = state == SRAM_REQ;
  assign rq_wr_o = wr;
  assign addr_o = addr;
  assign wr_data_o = wdata;
  assign h_rd_valid_o = h_rd_valid;
  assign h_rd_data_o = rdata;
  assign res_valid_o = state == RESULT;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      rr <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      h_rd_valid <= 1'b0;
      p <= '0;
      n <= '0;
      sign <= 1'b0;
      last <= 1'b0;
      cnt <= '0;
    end else begin
      h_rd_valid <= 1'b0;
      if (grant_host || grant_mac) rr <= grant_host;
      if (grant_host) begin
        addr <= h_addr_i;
        wr <= h_rq_wr_i;
        wdata <= h_wr_data_i;
      end
      // a row flagged both +1 and -1 resolves to -1
      if (accept) begin
        p <= pl_p_i & ~pl_n_i;
        n <= pl_n_i;
        sign <= pl_sign_i;
        last <= pl_last_i;
        cnt <= cfg_settle_i;
      end else if (state == MAC_DRIVE && cnt != '0) cnt <= cnt - 1'b1;
      case (state)
        IDLE: state <= grant_host ? SRAM_REQ : grant_mac ? MAC_DRIVE : IDLE;
        SRAM_REQ: if (rq_ready_i) state <= wr ? IDLE : SRAM_RD;
        SRAM_RD: if (rd_valid_i) begin
          rdata <= rd_data_i;
          h_rd_valid <= 1'b1;
          state <= IDLE;
        end
        MAC_DRIVE: if (cnt == '0) state <= MAC_SAMPLE;
        MAC_SAMPLE: state <= last ? RESULT : accept ? MAC_DRIVE : MAC_WAIT;
        MAC_WAIT: if (accept) state <= MAC_DRIVE;
        RESULT: if (res_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  for (genvar c = 0; c < numCols; c++) begin : g_col
    qracc_shift_acc #(.ADC_BITS(numAdcBits), .ACC_W(accBits)) u_acc (
      .clk,
      .nrst,
      .clr(grant_mac),
      .en(state == MAC_SAMPLE),
      .sign,
      .code(adc_out_i[c*numAdcBits +: numAdcBits]),
      .acc(res_data_o[c*accBits +: accBits])
    );
  end
endmodule

// File: tb/tb_qracc_column_scheduler.sv
// tb_qracc_column_scheduler: directed vectors for host SRAM access, MAC planes and arbitration.
module tb_qracc_column_scheduler;
  logic clk = 0, nrst = 0;
  logic [7:0] cfg_settle_i = 0;
  logic h_rq_valid_i = 0, h_rq_ready_o, h_rq_wr_i = 0, h_rd_valid_o;
  logic [6:0] h_addr_i = 0, addr_o;
  logic [0:0] h_wr_data_i = 0, h_rd_data_o, wr_data_o, rd_data_i = 0;
  logic pl_valid_i = 0, pl_ready_o, pl_sign_i = 0, pl_last_i = 0;
  logic [127:0] pl_p_i = 0, pl_n_i = 0, data_p_o, data_n_o;
  logic res_valid_o, res_ready_i = 0, mac_en_o, rq_valid_o, rq_wr_o, rq_ready_i = 0, rd_valid_i = 0;
  logic [15:0] res_data_o;
  logic [3:0] adc_out_i = 0;
  int total = 0, bad = 0, en_cycles;
  always #5 clk = ~clk;
  qracc_column_scheduler dut (
    .clk(clk), .nrst(nrst), .cfg_settle_i(cfg_settle_i),
    .h_rq_valid_i(h_rq_valid_i), .h_rq_ready_o(h_rq_ready_o), .h_rq_wr_i(h_rq_wr_i),
    .h_addr_i(h_addr_i), .h_wr_data_i(h_wr_data_i), .h_rd_valid_o(h_rd_valid_o),
    .h_rd_data_o(h_rd_data_o), .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o),
    .pl_p_i(pl_p_i), .pl_n_i(pl_n_i), .pl_sign_i(pl_sign_i), .pl_last_i(pl_last_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .mac_en_o(mac_en_o), .data_p_o(data_p_o), .data_n_o(data_n_o), .rq_valid_o(rq_valid_o),
    .rq_wr_o(rq_wr_o), .addr_o(addr_o), .wr_data_o(wr_data_o), .adc_out_i(adc_out_i),
    .rq_ready_i(rq_ready_i), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic plane(input logic [127:0] p, input logic [127:0] n, input logic s, input logic l, input logic [3:0] adc);
    pl_valid_i = 1; pl_p_i = p; pl_n_i = n; pl_sign_i = s; pl_last_i = l; adc_out_i = adc;
  endtask
  initial begin
    #2;
    chk("rst_mac_en", mac_en_o, 0);
    chk("rst_rq_valid", rq_valid_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_h_rd_valid", h_rd_valid_o, 0);
    chk("rst_res_data", res_data_o, 0);
    step(); step();
    nrst = 1;
    // 1: reset in the middle of MAC_DRIVE
    cfg_settle_i = 5;
    plane(128'h4, 0, 0, 1, 4'd12);
    #1 chk("t1_pl_ready", pl_ready_o, 1);
    step();
    pl_valid_i = 0;
    #1 chk("t1_drive_en", mac_en_o, 1);
    chk("t1_drive_p", data_p_o, 128'h4);
    step();
    nrst = 0;
    #1 chk("t1_abort_en", mac_en_o, 0);
    chk("t1_abort_p", data_p_o, 0);
    chk("t1_abort_res", res_valid_o, 0);
    step();
    nrst = 1;
    // 2: host write, rq_ready arrives in the third request cycle
    h_rq_valid_i = 1; h_rq_wr_i = 1; h_addr_i = 5; h_wr_data_i = 1;
    #1 chk("t2_h_ready", h_rq_ready_o, 1);
    chk("t2_pl_ready", pl_ready_o, 0);
    step();
    h_rq_valid_i = 0; h_addr_i = 0; h_wr_data_i = 0;
    for (int i = 0; i < 3; i++) begin
      rq_ready_i = (i == 2);
      #1 chk("t2_rq_valid", rq_valid_o, 1);
      chk("t2_no_mac", mac_en_o, 0);
      chk("t2_addr", addr_o, 5);
      chk("t2_wr", {rq_wr_o, wr_data_o}, 2'b11);
      step();
    end
    rq_ready_i = 0;
    #1 chk("t2_rq_low", rq_valid_o, 0);
    // 3: host read, rd_valid two cycles after the handshake
    h_rq_valid_i = 1; h_rq_wr_i = 0; h_addr_i = 5;
    #1 chk("t3_h_ready", h_rq_ready_o, 1);
    step();
    h_rq_valid_i = 0; rq_ready_i = 1;
    #1 chk("t3_rq_rd", {rq_valid_o, rq_wr_o}, 2'b10);
    step();
    rq_ready_i = 0;
    #1 chk("t3_rq_low", rq_valid_o, 0);
    step();
    rd_valid_i = 1; rd_data_i = 1;
    #1 chk("t3_not_yet", h_rd_valid_o, 0);
    step();
    rd_valid_i = 0; rd_data_i = 0;
    #1 chk("t3_rd_valid", h_rd_valid_o, 1);
    chk("t3_rd_data", h_rd_data_o, 1);
    step();
    chk("t3_rd_pulse", h_rd_valid_o, 0);
    // 4: settle 2, single plane, adc 12 -> +4; overlapping row resolves to -1
    cfg_settle_i = 2;
    plane(128'h3, 128'h2, 0, 1, 4'd12);
    #1 chk("t4_pl_ready", pl_ready_o, 1);
    step();
    pl_valid_i = 0;
    #1 chk("t4_data_p", data_p_o, 128'h1);
    chk("t4_data_n", data_n_o, 128'h2);
    en_cycles = 0;
    for (int i = 0; i < 10 && mac_en_o; i++) begin
      en_cycles++;
      step();
    end
    chk("t4_en_cycles", en_cycles, 4);
    chk("t4_res_valid", res_valid_o, 1);
    chk("t4_res_data", res_data_o, 16'd4);
    chk("t4_res_dp", data_p_o, 0);
    step();
    chk("t4_res_hold", {res_valid_o, res_data_o}, {1'b1, 16'd4});
    res_ready_i = 1;
    step();
    res_ready_i = 0;
    #1 chk("t4_res_drop", res_valid_o, 0);
    // 5: three planes MSB first, sign 1,0,0, adc 9,8,15 -> +3; exercises WAIT and back-to-back accept
    cfg_settle_i = 0;
    plane(128'h1, 0, 1, 0, 4'd9);
    #1 chk("t5_p1_ready", pl_ready_o, 1);
    step();
    pl_valid_i = 0;
    step();
    step();
    chk("t5_wait_en", mac_en_o, 1);
    chk("t5_wait_ready", pl_ready_o, 0);
    plane(128'h1, 0, 0, 0, 4'd8);
    #1 chk("t5_p2_ready", pl_ready_o, 1);
    step();
    plane(128'h1, 0, 0, 1, 4'd8);
    #1 chk("t5_drive_ready", pl_ready_o, 0);
    step();
    chk("t5_p3_ready", pl_ready_o, 1);
    step();
    pl_valid_i = 0; adc_out_i = 4'd15;
    step();
    step();
    chk("t5_res_valid", res_valid_o, 1);
    chk("t5_res_data", res_data_o, 16'd3);
    res_ready_i = 1;
    step();
    res_ready_i = 0;
    // 6: contention alternates host then MAC; host stalls during the job
    h_rq_valid_i = 1; h_rq_wr_i = 1; h_addr_i = 9;
    plane(128'h8, 0, 0, 1, 4'd10);
    #1 chk("t6_host_first", {h_rq_ready_o, pl_ready_o}, 2'b10);
    step();
    h_rq_valid_i = 0; rq_ready_i = 1;
    #1 chk("t6_sram_no_mac", {rq_valid_o, mac_en_o}, 2'b10);
    step();
    rq_ready_i = 0; h_rq_valid_i = 1;
    #1 chk("t6_mac_second", {h_rq_ready_o, pl_ready_o}, 2'b01);
    step();
    pl_valid_i = 0;
    #1 chk("t6_stall_drive", h_rq_ready_o, 0);
    step();
    chk("t6_stall_sample", h_rq_ready_o, 0);
    step();
    chk("t6_res", {res_valid_o, res_data_o}, {1'b1, 16'd2});
    chk("t6_stall_result", h_rq_ready_o, 0);
    res_ready_i = 1;
    step();
    res_ready_i = 0;
    #1 chk("t6_host_after", h_rq_ready_o, 1);
    step();
    h_rq_valid_i = 0; rq_ready_i = 1;
    step();
    rq_ready_i = 0;
    #1 chk("t6_idle", {rq_valid_o, mac_en_o}, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
